booth_stream_sequencer: RTL and testbench
=========================================

// Module: booth_stream_sequencer
// PURPOSE
//  Parametrised, double-buffered successor to the ACFIR NTT front end. Accepts packed coefficient beats over valid/ready,
//  radix-4 Booth-recodes them into digit-serial (n2,p,pp) streams per slot, and sequences STAGES passes of DIGITS cycles
//  into the routing network. Decodes routed per-lane selects into one/onen/two/twon and builds sign-encoded partial products.
//  Ping-pong banks let the next coefficient set load while the current one runs. Optional single-pass mode.
// PARAMETERS
//  LANES      64  Booth lanes (butterfly units); SLOTS = 2*LANES routing slots
//  COEF_W     12  coefficient width (even); DIGITS = COEF_W/2 + 2 (localparam, 2 pad digits)
//  CPB         4  coefficients per input beat; SLOTS % CPB == 0; BEATS = SLOTS/CPB
//  STAGES      8  passes per run in recirculate mode (LOGN+1)
//  PP_W       13  multiplicand width; partial product is PP_W+1 bits
// PORTS
//  clk         in   1               clock
//  rst         in   1               synchronous, active-high reset
//  s_valid     in   1               coefficient beat valid
//  s_ready     out  1               beat accepted when s_valid & s_ready
//  s_data      in   CPB*COEF_W      beat; coefficient c at [c*COEF_W +: COEF_W]
//  mode_recirc in   1               1: STAGES passes with feedback; 0: single pass; sampled with start
//  start       in   1               run request (level, sampled each cycle)
//  busy        out  1               run in progress
//  done        out  1               one-cycle pulse at end of run
//  dig_n2/dig_p/dig_pp out SLOTS    digit streams to routing network
//  fb_n2/fb_p/fb_pp    in  SLOTS    routed digits fed back for passes >= 1
//  wn2/wp/wpp  in   LANES           routed Booth triplet per lane
//  mcand       in   LANES*PP_W      multiplicand per lane
//  one/onen/two/twon out LANES      registered Booth controls
//  pp          out  LANES*(PP_W+1)  registered partial products
//  pp_valid    out  1               pp/controls valid
// BEHAVIOUR
//  Reset: all outputs 0, both banks empty, load_bank=0, FSM IDLE; s_ready=0 while rst high, 1 the cycle after.
//  Recoding, coefficient x into digit j<COEF_W/2: n2=x[2j+1], p=x[2j], pp=(j==0)?0:x[2j-1]; digit COEF_W/2: n2=p=0,
//   pp=x[COEF_W-1]; digit COEF_W/2+1: all 0. Beat k writes slots k*CPB..k*CPB+CPB-1 of load_bank.
//  Banks: beat counter per load; BEATS-th beat sets bank full (registered) and toggles load_bank. s_ready = load_bank not full.
//  FSM IDLE->RUN when start & run candidate bank full (full flag seen only next cycle after final beat); start otherwise
//   ignored, including during RUN. RUN->IDLE after last cycle; bank released empty the cycle done pulses.
//  RUN counter cnt 0..LEN-1, LEN = (mode_recirc?STAGES:1)*DIGITS. cnt<DIGITS: dig_* = bank digit cnt per slot;
//   cnt>=DIGITS: dig_* = fb_*. Outside RUN dig_* = 0. done=1 in cycle after cnt==LEN-1 (LEN+1 cycles after start sample).
//  Back-to-back: start high in done cycle with other bank full -> RUN next cycle, no gap beyond that cycle.
//  Decode {wn2,wp,wpp}: 000/111 zero; 001/010 one; 011 two; 100 twon; 101/110 onen.
//  pp = zero ? 0 : {twon|onen, m[PP_W-1]|onen, m[PP_W-2:1], m[0]|twon}; registered: inputs cycle t -> outputs t+1.
//  pp_valid = busy delayed 1 cycle; controls/pp forced 0 when not valid.
//  rst mid-run: next cycle busy=done=pp_valid=0, banks empty, partial load discarded.
// STRUCTURE
//  Package acfir_booth_pkg: DIGITS/BEATS localparam functions, FSM state encoding, booth_decode function.
//  Sub-module booth_lane_pp: one lane decode + pp build + output register, generated LANES times.
//  Top holds banks (2 x 3 x SLOTS*DIGITS bits), beat/run counters, FSM, digit mux.
// TESTING
//  1 Load 32 beats, all coef 12'h001; start -> cnt0 dig_p=all 1, dig_n2=dig_pp=0; cnt1..7 all 0; done 65 cycles after start.
//  2 Coef 12'h800 -> digit5 n2=1,p=0,pp=0; digit6 pp=1; digit7 all 0; digit0..4 all 0.
//  3 mcand=13'h0ABC: sel 011 -> two=1, pp=14'h0ABC; 100 -> pp=14'h2ABD; 101 -> pp=14'h3ABC; 000/111 -> pp=0.
//  4 Load bank1 during bank0 run: s_ready=1 until 32nd beat then 0; start held -> second run begins cycle after done.
//  5 rst at cnt=20 -> next cycle busy=0, pp_valid=0, s_ready=1; start without reload ignored.
//  6 mode_recirc=0 -> done 9 cycles after start; fb_* ignored; start with no full bank -> busy stays 0.

Source files
------------

// File: rtl/acfir_booth_pkg.sv
// Shared sizing helpers, FSM encoding and Booth select decode
// for the booth stream sequencer.
package acfir_booth_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic one;
    logic onen;
    logic two;
    logic twon;
  } booth_ctl_t;

  function automatic int digits_f(input int coef_w);
    return coef_w / 2 + 2;
  endfunction

  function automatic int beats_f(input int slots, input int cpb);
    return slots / cpb;
  endfunction

  function automatic booth_ctl_t booth_decode(input logic [2:0] s);
    booth_ctl_t c;
    c = '0;
    unique case (1'b1)
      (s == 3'b001), (s == 3'b010): c.one  = 1'b1;
      (s == 3'b011):                c.two  = 1'b1;
      (s == 3'b100):                c.twon = 1'b1;
      (s == 3'b101), (s == 3'b110): c.onen = 1'b1;
      default:                      c      = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_lane_pp.sv
// One Booth lane: decodes the routed select triplet and registers
// the controls plus the sign-encoded partial product.
module booth_lane_pp
  import acfir_booth_pkg::*;
#(
  parameter int PP_W = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wn2,
  input  logic            wp,
  input  logic            wpp,
  input  logic [PP_W-1:0] mcand,
  output logic            one,
  output logic            onen,
  output logic            two,
  output logic            twon,
  output logic [PP_W:0]   pp
);

  booth_ctl_t      ctl;
  logic [PP_W:0]   pp_d;

  always_comb begin
    ctl  = booth_decode({wn2, wp, wpp});
    pp_d = '0;
    if (ctl != '0) begin
      pp_d = {ctl.twon | ctl.onen,
              mcand[PP_W-1] | ctl.onen,
              mcand[PP_W-2:1],
              mcand[0] | ctl.twon};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      {one, onen, two, twon} <= '0;
      pp <= '0;
    end else begin
      {one, onen, two, twon} <= ctl;
      pp <= pp_d;
    end
  end

endmodule

// File: rtl/booth_stream_sequencer.sv
// Double-buffered Booth recoder: loads coefficient beats into ping-pong
// banks, streams digits per pass and builds per-lane partial products.
module booth_stream_sequencer
  import acfir_booth_pkg::*;
#(
  parameter int LANES  = 64,
  parameter int COEF_W = 12,
  parameter int CPB    = 4,
  parameter int STAGES = 8,
  parameter int PP_W   = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [CPB*COEF_W-1:0]      s_data,
  input  logic                       mode_recirc,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [2*LANES-1:0]         dig_n2,
  output logic [2*LANES-1:0]         dig_p,
  output logic [2*LANES-1:0]         dig_pp,
  input  logic [2*LANES-1:0]         fb_n2,
  input  logic [2*LANES-1:0]         fb_p,
  input  logic [2*LANES-1:0]         fb_pp,
  input  logic [LANES-1:0]           wn2,
  input  logic [LANES-1:0]           wp,
  input  logic [LANES-1:0]           wpp,
  input  logic [LANES*PP_W-1:0]      mcand,
  output logic [LANES-1:0]           one,
  output logic [LANES-1:0]           onen,
  output logic [LANES-1:0]           two,
  output logic [LANES-1:0]           twon,
  output logic [LANES*(PP_W+1)-1:0]  pp,
  output logic                       pp_valid
);

  localparam int SLOTS   = 2 * LANES;
  localparam int DIGITS  = digits_f(COEF_W);
  localparam int BEATS   = beats_f(SLOTS, CPB);
  localparam int HALF    = COEF_W / 2;
  localparam int RUN_MAX = STAGES * DIGITS;
  localparam int CW      = $clog2(RUN_MAX);
  localparam int DW      = $clog2(DIGITS);
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [1:0]    full_q, full_d;
  logic          rec_q, rec_d;
  logic          rb_q, rb_d;
  logic          lb_q, lb_d;
  logic          done_q, done_d;
  logic          pv_q;
  logic          acc, go, last, in_bank;
  logic [CW-1:0] last_cnt;
  logic [DW-1:0] dsel;

  assign s_ready  = ~rst & ~full_q[lb_q];
  assign acc      = s_valid & s_ready;
  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign pp_valid = pv_q;
  assign go       = (state_q == S_IDLE) & start & full_q[rb_q];
  assign last_cnt = rec_q ? CW'(RUN_MAX - 1) : CW'(DIGITS - 1);
  assign last     = busy & (cnt_q == last_cnt);
  assign in_bank  = cnt_q < CW'(DIGITS);
  assign dsel     = cnt_q[DW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    rb_d    = rb_q;
    lb_d    = lb_q;
    beat_d  = beat_q;
    full_d  = full_q;
    done_d  = 1'b0;
    if (go) begin
      state_d = S_RUN;
      cnt_d   = '0;
      rec_d   = mode_recirc;
    end else if (last) begin
      state_d       = S_IDLE;
      done_d        = 1'b1;
      full_d[rb_q]  = 1'b0;
      rb_d          = ~rb_q;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
    // the loading bank is never the running one, so no flag conflict
    if (acc) begin
      if (beat_q == BW'(BEATS - 1)) begin
        beat_d       = '0;
        full_d[lb_q] = 1'b1;
        lb_d         = ~lb_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      full_q  <= '0;
      rec_q   <= 1'b0;
      rb_q    <= 1'b0;
      lb_q    <= 1'b0;
      done_q  <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      full_q  <= full_d;
      rec_q   <= rec_d;
      rb_q    <= rb_d;
      lb_q    <= lb_d;
      done_q  <= done_d;
      pv_q    <= busy;
    end
  end

  logic [CPB-1:0][DIGITS-1:0] rn2, rp, rpp;

  for (genvar c = 0; c < CPB; c++) begin : g_rec
    for (genvar j = 0; j < DIGITS; j++) begin : g_dig
      if (j < HALF) begin : g_lo
        assign rn2[c][j] = s_data[c*COEF_W + 2*j + 1];
        assign rp[c][j]  = s_data[c*COEF_W + 2*j];
        if (j == 0) begin : g_first
          assign rpp[c][j] = 1'b0;
        end else begin : g_rest
          assign rpp[c][j] = s_data[c*COEF_W + 2*j - 1];
        end
      end else if (j == HALF) begin : g_sign
        assign rn2[c][j] = 1'b0;
        assign rp[c][j]  = 1'b0;
        assign rpp[c][j] = s_data[c*COEF_W + COEF_W - 1];
      end else begin : g_pad
        assign rn2[c][j] = 1'b0;
        assign rp[c][j]  = 1'b0;
        assign rpp[c][j] = 1'b0;
      end
    end
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    localparam int            C = s % CPB;
    localparam logic [BW-1:0] K = BW'(s / CPB);
    logic [DIGITS-1:0] n2_q [2];
    logic [DIGITS-1:0] p_q  [2];
    logic [DIGITS-1:0] pp_q [2];

    always_ff @(posedge clk) begin
      if (acc && beat_q == K) begin
        n2_q[lb_q] <= rn2[C];
        p_q[lb_q]  <= rp[C];
        pp_q[lb_q] <= rpp[C];
      end
    end

    assign dig_n2[s] = busy & (in_bank ? n2_q[rb_q][dsel] : fb_n2[s]);
    assign dig_p[s]  = busy & (in_bank ? p_q[rb_q][dsel]  : fb_p[s]);
    assign dig_pp[s] = busy & (in_bank ? pp_q[rb_q][dsel] : fb_pp[s]);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    booth_lane_pp #(.PP_W(PP_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (busy),
      .wn2   (wn2[l]),
      .wp    (wp[l]),
      .wpp   (wpp[l]),
      .mcand (mcand[l*PP_W +: PP_W]),
      .one   (one[l]),
      .onen  (onen[l]),
      .two   (two[l]),
      .twon  (twon[l]),
      .pp    (pp[l*(PP_W+1) +: PP_W+1])
    );
  end

endmodule

// File: tb/tb_booth_stream_sequencer.sv
// Self-checking bench for booth_stream_sequencer: digit streams,
// bank ping-pong, run timing and per-lane partial products.
module tb_booth_stream_sequencer;

  localparam int LANES  = 64;
  localparam int COEF_W = 12;
  localparam int CPB    = 4;
  localparam int STAGES = 8;
  localparam int PP_W   = 13;
  localparam int SLOTS  = 128;
  localparam int DIGITS = 8;
  localparam int BEATS  = 32;
  localparam int NV     = 11;
  localparam int PPW1   = PP_W + 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      s_valid;
  logic                      s_ready;
  logic [CPB*COEF_W-1:0]     s_data;
  logic                      mode_recirc;
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [SLOTS-1:0]          dig_n2, dig_p, dig_pp;
  logic [SLOTS-1:0]          fb_n2, fb_p, fb_pp;
  logic [LANES-1:0]          wn2, wp, wpp;
  logic [LANES*PP_W-1:0]     mcand;
  logic [LANES-1:0]          one, onen, two, twon;
  logic [LANES*PPW1-1:0]     pp;
  logic                      pp_valid;

  always #5 clk = ~clk;

  booth_stream_sequencer #(
    .LANES(LANES), .COEF_W(COEF_W), .CPB(CPB),
    .STAGES(STAGES), .PP_W(PP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mode_recirc(mode_recirc), .start(start),
    .busy(busy), .done(done),
    .dig_n2(dig_n2), .dig_p(dig_p), .dig_pp(dig_pp),
    .fb_n2(fb_n2), .fb_p(fb_p), .fb_pp(fb_pp),
    .wn2(wn2), .wp(wp), .wpp(wpp), .mcand(mcand),
    .one(one), .onen(onen), .two(two), .twon(twon),
    .pp(pp), .pp_valid(pp_valid)
  );

  typedef struct {
    logic [2:0]      sel;
    logic [PP_W-1:0] m;
    logic [3:0]      ctl;
    logic [PP_W:0]   ppv;
  } vec_t;

  typedef struct {
    logic [LANES-1:0]      one, onen, two, twon;
    logic [LANES*PPW1-1:0] ppv;
  } exp_t;

  vec_t        vt [NV];
  exp_t        pq [$];
  logic [COEF_W-1:0] bank_cf [2][SLOTS];
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [SLOTS-1:0] got,
                     input logic [SLOTS-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [2:0] exp_digit(input logic [COEF_W-1:0] x,
                                           input int j);
    int v;
    v = int'(x);
    if (j < COEF_W / 2)
      return {1'(v >> (2*j+1)), 1'(v >> (2*j)),
              (j == 0) ? 1'b0 : 1'(v >> (2*j-1))};
    if (j == COEF_W / 2)
      return {2'b00, x[COEF_W-1]};
    return 3'b000;
  endfunction

  task automatic step(input bit eb, input bit ed, input int cnt,
                      input int bk);
    exp_t e;
    vec_t v;
    logic [SLOTS-1:0] en2, ep, epp;
    logic [2:0] d;
    int bad;
    @(posedge clk);
    #1;
    if (pq.size() > 0) begin
      e = pq.pop_front();
      chk("pp_valid", SLOTS'(pp_valid), SLOTS'(1));
    end else begin
      e = '{default: '0};
      chk("pp_valid", SLOTS'(pp_valid), SLOTS'(0));
    end
    chk("one", SLOTS'(one), SLOTS'(e.one));
    chk("onen", SLOTS'(onen), SLOTS'(e.onen));
    chk("two", SLOTS'(two), SLOTS'(e.two));
    chk("twon", SLOTS'(twon), SLOTS'(e.twon));
    n_chk++;
    if (pp !== e.ppv) begin
      n_fail++;
      bad = 0;
      for (int l = LANES - 1; l >= 0; l--)
        if (pp[l*PPW1 +: PPW1] !== e.ppv[l*PPW1 +: PPW1]) bad = l;
      $display("FAIL pp lane %0d: got %h want %h", bad,
               pp[bad*PPW1 +: PPW1], e.ppv[bad*PPW1 +: PPW1]);
    end
    chk("busy", SLOTS'(busy), SLOTS'(eb));
    chk("done", SLOTS'(done), SLOTS'(ed));
    cyc++;
    for (int l = 0; l < LANES; l++) begin
      v = vt[(cyc * 3 + l) % NV];
      wn2[l] = v.sel[2];
      wp[l]  = v.sel[1];
      wpp[l] = v.sel[0];
      mcand[l*PP_W +: PP_W] = v.m;
      e.one[l]  = v.ctl[3];
      e.onen[l] = v.ctl[2];
      e.two[l]  = v.ctl[1];
      e.twon[l] = v.ctl[0];
      e.ppv[l*PPW1 +: PPW1] = v.ppv;
    end
    fb_n2 = {$urandom, $urandom, $urandom, $urandom};
    fb_p  = {$urandom, $urandom, $urandom, $urandom};
    fb_pp = {$urandom, $urandom, $urandom, $urandom};
    if (eb && !rst) pq.push_back(e);
    #1;
    en2 = '0;
    ep  = '0;
    epp = '0;
    if (eb) begin
      if (cnt < DIGITS) begin
        for (int s = 0; s < SLOTS; s++) begin
          d = exp_digit(bank_cf[bk][s], cnt);
          en2[s] = d[2];
          ep[s]  = d[1];
          epp[s] = d[0];
        end
      end else begin
        en2 = fb_n2;
        ep  = fb_p;
        epp = fb_pp;
      end
    end
    chk("dig_n2", dig_n2, en2);
    chk("dig_p", dig_p, ep);
    chk("dig_pp", dig_pp, epp);
  endtask

  task automatic load(input int bk, input int nb);
    int g;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++)
        s_data[c*COEF_W +: COEF_W] = bank_cf[bk][k*CPB + c];
      s_valid = 1'b1;
      g = 0;
      while (!s_ready && g < 100) begin
        @(posedge clk);
        #1;
        g++;
      end
      chk("s_ready_beat", SLOTS'(s_ready), SLOTS'(1));
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    mode_recirc = 1'b0; start = 1'b0;
    fb_n2 = '0; fb_p = '0; fb_pp = '0;
    wn2 = '0; wp = '0; wpp = '0; mcand = '0;

    vt[0]  = '{3'b000, 13'h0ABC, 4'b0000, 14'h0000};
    vt[1]  = '{3'b001, 13'h0ABC, 4'b1000, 14'h0ABC};
    vt[2]  = '{3'b010, 13'h0ABC, 4'b1000, 14'h0ABC};
    vt[3]  = '{3'b011, 13'h0ABC, 4'b0010, 14'h0ABC};
    vt[4]  = '{3'b100, 13'h0ABC, 4'b0001, 14'h2ABD};
    vt[5]  = '{3'b101, 13'h0ABC, 4'b0100, 14'h3ABC};
    vt[6]  = '{3'b110, 13'h0ABC, 4'b0100, 14'h3ABC};
    vt[7]  = '{3'b111, 13'h0ABC, 4'b0000, 14'h0000};
    vt[8]  = '{3'b100, 13'h1555, 4'b0001, 14'h3555};
    vt[9]  = '{3'b001, 13'h1555, 4'b1000, 14'h1555};
    vt[10] = '{3'b110, 13'h1FFF, 4'b0100, 14'h3FFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", SLOTS'(s_ready), SLOTS'(0));
    chk("rst_busy", SLOTS'(busy), SLOTS'(0));
    chk("rst_done", SLOTS'(done), SLOTS'(0));
    chk("rst_pp_valid", SLOTS'(pp_valid), SLOTS'(0));
    chk("rst_dig_p", dig_p, '0);
    chk("rst_pp", pp[SLOTS-1:0], '0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", SLOTS'(s_ready), SLOTS'(1));

    // back-to-back runs, bank1 filled while bank0 runs
    for (int s = 0; s < SLOTS; s++) begin
      bank_cf[0][s] = 12'h001;
      bank_cf[1][s] = (s % 2 == 0) ? 12'h800 : 12'($urandom_range(0, 4095));
    end
    load(0, BEATS);
    chk("ready_bank1_empty", SLOTS'(s_ready), SLOTS'(1));
    mode_recirc = 1'b1;
    start = 1'b1;
    fork
      begin
        for (int i = 0; i < STAGES * DIGITS; i++) step(1, 0, i, 0);
        step(0, 1, -1, 0);
        for (int i = 0; i < STAGES * DIGITS; i++) begin
          step(1, 0, i, 1);
          if (i == 0) start = 1'b0;
        end
        step(0, 1, -1, 1);
        step(0, 0, -1, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        load(1, BEATS);
        chk("ready_both_full", SLOTS'(s_ready), SLOTS'(0));
      end
    join

    // reset in the middle of a run with a partial load pending
    for (int s = 0; s < SLOTS; s++) begin
      bank_cf[0][s] = 12'($urandom_range(0, 4095));
      bank_cf[1][s] = 12'hFFF;
    end
    load(0, BEATS);
    load(1, 5);
    mode_recirc = 1'b1;
    start = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      step(1, 0, i, 0);
      if (i == 0) start = 1'b0;
    end
    rst = 1'b1;
    pq.delete();
    step(0, 0, -1, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_s_ready", SLOTS'(s_ready), SLOTS'(1));
    start = 1'b1;
    repeat (3) step(0, 0, -1, 0);
    start = 1'b0;

    // single-pass run; mode change after start must not matter
    for (int s = 0; s < SLOTS; s++) bank_cf[0][s] = 12'h800;
    load(0, BEATS);
    mode_recirc = 1'b0;
    start = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      step(1, 0, i, 0);
      if (i == 0) begin
        start = 1'b0;
        mode_recirc = 1'b1;
      end
    end
    step(0, 1, -1, 0);
    step(0, 0, -1, 0);

    start = 1'b1;
    repeat (3) step(0, 0, -1, 0);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
